// File: rtl/vmem_pkg.sv
// vmem_pkg: shared types and constants for the vector memory access unit
package vmem_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, VXFER, DRAIN} vmem_state_t;
endpackage

// File: rtl/vmem_access_unit_if.sv
// vmem_access_unit_if: M-stage memory controls plus single-port data RAM bus
interface vmem_access_unit_if #(parameter int LANES = 4, parameter int AW = 10);
  logic memwriteM;
  logic memtoregM;
  logic memsrcM;
  logic memdataM;
  logic [31:0] addrM;
  logic [31:0] wdata_sM;
  logic [LANES*32-1:0] wdata_vM;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [LANES*32-1:0] rdata_v;
  logic memstallM;
  modport slave (
    input memwriteM, memtoregM, memsrcM, memdataM, addrM, wdata_sM, wdata_vM, mem_rdata,
    output mem_addr, mem_we, mem_wdata, rdata_v, memstallM
  );
  modport master (
    output memwriteM, memtoregM, memsrcM, memdataM, addrM, wdata_sM, wdata_vM, mem_rdata,
    input mem_addr, mem_we, mem_wdata, rdata_v, memstallM
  );
endinterface

// File: rtl/vlane_buf.sv
// vlane_buf: LANES x 32-bit lane register with indexed write
module vlane_buf
  import vmem_pkg::*;
#(
  parameter int LANES = 4,
  localparam int IW = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [IW-1:0]           idx,
  input  logic [WORD_W-1:0]       d,
  output logic [LANES*WORD_W-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (we) q[idx*WORD_W +: WORD_W] <= d;
endmodule

// File: rtl/vmem_access_unit.sv
// vmem_access_unit: sequences scalar and multi-lane vector loads/stores onto a 1-cycle-latency RAM
module vmem_access_unit
  import vmem_pkg::*;
#(
  parameter int LANES = 4,
  parameter int AW = 10
) (
  input logic clk,
  input logic reset,
  vmem_access_unit_if.slave bus
);
  localparam int BW = $clog2(LANES);
  localparam logic [BW-1:0] LAST = BW'(LANES - 1);
  vmem_state_t state, nextState;
  logic [BW-1:0] beat, nextBeat, k, capIdx;
  logic vStore, nextVStore, capWe, we, stall, req;
  logic unusedAddr;
  assign unusedAddr = ^{bus.addrM[31:AW+2], bus.addrM[1:0]};
  always_comb begin
    req = bus.memwriteM | bus.memtoregM;
    k = state == IDLE ? '0 : beat;
    capIdx = state == DRAIN ? LAST : beat - 1'b1;
    nextState = state;
    nextBeat = beat;
    nextVStore = vStore;
    capWe = 1'b0;
    we = 1'b0;
    stall = 1'b0;
    unique case (state)
      IDLE: begin
        we = bus.memwriteM;
        if (req && bus.memsrcM) begin
          stall = 1'b1;
          nextState = VXFER;
          nextBeat = BW'(1);
          nextVStore = bus.memwriteM;
        end
      end
      VXFER: begin
        we = vStore;
        capWe = ~vStore;
        stall = ~vStore | (beat != LAST);
        nextState = beat != LAST ? VXFER : vStore ? IDLE : DRAIN;
        nextBeat = beat != LAST ? beat + 1'b1 : vStore ? '0 : beat;
      end
      DRAIN: begin
        capWe = 1'b1;
        nextState = IDLE;
        nextBeat = '0;
      end
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      vStore <= 1'b0;
    end else begin
      state <= nextState;
      beat <= nextBeat;
      vStore <= nextVStore;
    end
  // reset gates the bus immediately so an abandoned transfer issues no further writes
  assign bus.mem_we = we & ~reset;
  assign bus.memstallM = stall & ~reset;
  assign bus.mem_addr = reset ? '0 : bus.addrM[AW+1:2] + AW'(k);
  assign bus.mem_wdata = reset ? '0 : bus.memdataM ? bus.wdata_vM[k*WORD_W +: WORD_W] : bus.wdata_sM;
  vlane_buf #(.LANES(LANES)) u_buf (
    .clk(clk),
    .reset(reset),
    .we(capWe),
    .idx(capIdx),
    .d(bus.mem_rdata),
    .q(bus.rdata_v)
  );
endmodule

// File: tb/tb_vmem_access_unit.sv
// tb_vmem_access_unit: randomized scoreboard bench with a word-level memory reference model
module tb_vmem_access_unit;
  localparam int LANES = 4;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;
  localparam int VW = LANES * 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  vmem_access_unit_if #(.LANES(LANES), .AW(AW)) bus ();
  vmem_access_unit #(.LANES(LANES), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] ram [DEPTH];
  logic [31:0] refMem [DEPTH];
  logic [AW+31:0] wrQ [$];
  logic [VW:0] ldQ [$];
  int checks = 0;
  int failures = 0;
  bit ldPending = 1'b0;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end
  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // monitor: every RAM write pops the write queue; a load leaving M is checked in its W cycle
  always @(negedge clk) begin
    if (reset) ldPending = 1'b0;
    else begin
      if (ldPending) begin
        ldPending = 1'b0;
        if (ldQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ld_unexpected actual=load required=none");
        end else begin
          logic [VW:0] e;
          e = ldQ.pop_front();
          if (e[VW]) check("vload_data", bus.rdata_v, e[VW-1:0]);
          else check("sload_data", {{(VW-32){1'b0}}, bus.mem_rdata}, e[VW-1:0]);
        end
      end
      if (bus.mem_we) begin
        if (wrQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected actual=%0h:%0h required=none", bus.mem_addr, bus.mem_wdata);
        end else check("wr_beat", {bus.mem_addr, bus.mem_wdata}, wrQ.pop_front());
      end
      if (bus.memtoregM && !bus.memwriteM && !bus.memstallM) ldPending = 1'b1;
    end
  end
  task automatic idleCtl();
    bus.memwriteM = 0;
    bus.memtoregM = 0;
    bus.memsrcM = 0;
    bus.memdataM = 0;
    bus.addrM = 0;
    bus.wdata_sM = 0;
    bus.wdata_vM = 0;
  endtask
  task automatic resetState(input string tag);
    @(negedge clk);
    check({tag, "_stall"}, bus.memstallM, 0);
    check({tag, "_we"}, bus.mem_we, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_rdata_v"}, bus.rdata_v, 0);
  endtask
  // model: beat k touches word (addr/4 + k) mod DEPTH; cycles in M are 1, LANES or LANES+1
  task automatic issue(input bit w, input bit l, input bit v, input bit ds,
                       input logic [31:0] a, input logic [31:0] ws, input logic [VW-1:0] wv);
    int n, expCyc, cyc;
    bit st;
    logic [VW-1:0] val;
    logic [AW-1:0] wa;
    logic [31:0] d;
    n = v ? LANES : 1;
    val = '0;
    bus.memwriteM = w;
    bus.memtoregM = l;
    bus.memsrcM = v;
    bus.memdataM = ds;
    bus.addrM = a;
    bus.wdata_sM = ws;
    bus.wdata_vM = wv;
    for (int k = 0; k < n; k++) begin
      wa = AW'((a >> 2) + k);
      if (w) begin
        d = ds ? wv[32*k +: 32] : ws;
        wrQ.push_back({wa, d});
        refMem[wa] = d;
      end else val[32*k +: 32] = refMem[wa];
    end
    if (!w) ldQ.push_back({v, val});
    expCyc = !v ? 1 : w ? LANES : LANES + 1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      st = bus.memstallM;
      @(posedge clk);
      #1;
    end while (st && cyc < 3 * LANES);
    check("cycles_in_M", cyc, expCyc);
    idleCtl();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] r;
    logic [1:0] kind;
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom;
      ram[i] = r;
      refMem[i] = r;
    end
    for (int i = 0; i < 4; i++) begin
      ram[i] = 32'hA + i;
      refMem[i] = 32'hA + i;
    end
    idleCtl();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetState("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    resetState("after_reset");
    @(posedge clk);
    #1;
    issue(1, 0, 0, 0, 32'h40, 32'hDEADBEEF, '0);
    issue(1, 0, 1, 1, 32'h100, 32'h0, {32'd4, 32'd3, 32'd2, 32'd1});
    issue(0, 1, 1, 0, 32'h0, 32'h0, '0);
    @(negedge clk);
    check("t3_rdata_v", bus.rdata_v, {32'hD, 32'hC, 32'hB, 32'hA});
    @(posedge clk);
    #1;
    issue(0, 1, 1, 0, 32'h3F8, 32'h0, '0);
    issue(1, 0, 1, 0, 32'h3F8, 32'h55, {$urandom, $urandom, $urandom, $urandom});
    issue(0, 1, 1, 0, 32'h3F8, 32'h0, '0);
    issue(1, 0, 1, 1, 32'h40, 32'h0, {$urandom, $urandom, $urandom, $urandom});
    issue(0, 1, 0, 0, 32'h40, 32'h0, '0);
    issue(0, 1, 1, 0, 32'h3F8, 32'h0, '0);
    bus.memwriteM = 1;
    bus.memsrcM = 1;
    bus.memdataM = 1;
    bus.addrM = 32'h200;
    bus.wdata_vM = {32'h44, 32'h33, 32'h22, 32'h11};
    wrQ.push_back({8'h80, 32'h11});
    wrQ.push_back({8'h81, 32'h22});
    refMem[8'h80] = 32'h11;
    refMem[8'h81] = 32'h22;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idleCtl();
    @(posedge clk);
    #1;
    reset = 1'b0;
    resetState("mid_reset");
    @(posedge clk);
    #1;
    issue(0, 1, 1, 0, 32'h200, 32'h0, '0);
    repeat (60) begin
      kind = 2'($urandom_range(1, 3));
      issue(kind[1], kind[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            {$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("wrQ_empty", wrQ.size(), 0);
    check("ldQ_empty", ldQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
